// File: rtl/hpdcache_sram_scrub_pkg.sv
// Shared types for the SRAM scrub sequencer: top-level FSM state encoding.
package hpdcache_sram_scrub_pkg;

  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_INIT      = 2'd1,
    ST_RUN       = 2'd2,
    ST_SCRUB_CHK = 2'd3
  } scrub_state_e;

endpackage

// File: rtl/hpdcache_sram_scrub_ctrl_if.sv
// Client request/response bus of the scrub sequencer; master = cache client, slave = sequencer.
interface hpdcache_sram_scrub_ctrl_if #(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NDATA     = 1
) ();

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_we;
  logic [ADDR_SIZE-1:0]         req_addr;
  logic [NDATA*DATA_SIZE-1:0]   req_wdata;
  logic                         rsp_valid;
  logic [NDATA*DATA_SIZE-1:0]   rsp_rdata;
  logic [NDATA-1:0]             rsp_err_cor;
  logic [NDATA-1:0]             rsp_err_unc;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err_cor, rsp_err_unc
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err_cor, rsp_err_unc
  );

endinterface

// File: rtl/hpdcache_sram_scrub_timer.sv
// Scrub period counter: raises pend_o every SCRUB_PERIOD enabled cycles, held until clear_i.
module hpdcache_sram_scrub_timer #(
  parameter int unsigned SCRUB_PERIOD = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clear_i,
  output logic pend_o
);

  localparam int unsigned CW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;

  logic [CW-1:0] cnt_q;
  logic          pend_q;

  // The clearing cycle already counts, so idle scrubs land exactly SCRUB_PERIOD apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (clear_i) pend_q <= 1'b0;
      if (start_i && (!pend_q || clear_i)) begin
        if (cnt_q == CW'(SCRUB_PERIOD - 1)) begin
          cnt_q  <= '0;
          pend_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/hpdcache_sram_scrub_ctrl.sv
// Sequencer in front of an ECC SRAM: zero-init, client pass-through, background scrub with
// write-back of corrected entries.
module hpdcache_sram_scrub_ctrl
  import hpdcache_sram_scrub_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = 4,
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned DEPTH        = 2**ADDR_SIZE,
  parameter int unsigned NDATA        = 1,
  parameter int unsigned SCRUB_PERIOD = 1024,
  parameter int unsigned STARVE_MAX   = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  hpdcache_sram_scrub_ctrl_if.slave  bus,
  output logic                       sram_cs_o,
  output logic                       sram_we_o,
  output logic [ADDR_SIZE-1:0]       sram_addr_o,
  output logic [NDATA*DATA_SIZE-1:0] sram_wdata_o,
  input  logic [NDATA*DATA_SIZE-1:0] sram_rdata_i,
  input  logic [NDATA-1:0]           sram_err_cor_i,
  input  logic [NDATA-1:0]           sram_err_unc_i,
  input  logic                       scrub_en_i,
  output logic                       init_done_o,
  output logic                       scrub_unc_o,
  output logic [ADDR_SIZE-1:0]       scrub_unc_addr_o,
  output logic [CNT_W-1:0]           scrub_cor_cnt_o
);

  localparam int unsigned STW = $clog2(STARVE_MAX + 1);

  scrub_state_e         state_q;
  logic [ADDR_SIZE-1:0] scrub_addr_q;
  logic [STW-1:0]       starve_q;
  logic                 rsp_valid_q;
  logic                 init_done_q;
  logic                 scrub_unc_q;
  logic [ADDR_SIZE-1:0] scrub_unc_addr_q;
  logic [CNT_W-1:0]     cor_cnt_q;

  logic scrub_pend, scrub_grant, client_grant, cnt_en;
  logic any_cor, any_unc, wb_cor, addr_last;

  assign any_cor      = |sram_err_cor_i;
  assign any_unc      = |sram_err_unc_i;
  assign addr_last    = (scrub_addr_q == ADDR_SIZE'(DEPTH - 1));
  assign scrub_grant  = (state_q == ST_RUN) && scrub_pend &&
                        (!bus.req_valid || (starve_q == STW'(STARVE_MAX)));
  assign bus.req_ready = (state_q == ST_RUN) && !scrub_grant;
  assign client_grant = bus.req_valid && bus.req_ready;
  assign wb_cor       = (state_q == ST_SCRUB_CHK) && any_cor && !any_unc;
  assign cnt_en       = scrub_en_i && ((state_q == ST_RUN) || (state_q == ST_SCRUB_CHK));

  hpdcache_sram_scrub_timer #(
    .SCRUB_PERIOD (SCRUB_PERIOD)
  ) i_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (cnt_en),
    .clear_i (scrub_grant),
    .pend_o  (scrub_pend)
  );

  // Write-back happens in the check cycle itself, using the already-corrected read data.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = scrub_addr_q;
    sram_wdata_o = '0;
    unique case (state_q)
      ST_INIT: begin
        sram_cs_o = 1'b1;
        sram_we_o = 1'b1;
      end
      ST_RUN: begin
        if (scrub_grant) begin
          sram_cs_o = 1'b1;
        end else if (client_grant) begin
          sram_cs_o    = 1'b1;
          sram_we_o    = bus.req_we;
          sram_addr_o  = bus.req_addr;
          sram_wdata_o = bus.req_wdata;
        end
      end
      ST_SCRUB_CHK: begin
        if (wb_cor) begin
          sram_cs_o    = 1'b1;
          sram_we_o    = 1'b1;
          sram_wdata_o = sram_rdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RST;
      scrub_addr_q     <= '0;
      starve_q         <= '0;
      rsp_valid_q      <= 1'b0;
      init_done_q      <= 1'b0;
      scrub_unc_q      <= 1'b0;
      scrub_unc_addr_q <= '0;
      cor_cnt_q        <= '0;
    end else begin
      rsp_valid_q <= client_grant && !bus.req_we;
      scrub_unc_q <= 1'b0;
      unique case (state_q)
        ST_RST: state_q <= ST_INIT;
        ST_INIT: begin
          // Init walks the same address register the scrubber uses; it wraps back to 0.
          scrub_addr_q <= addr_last ? '0 : scrub_addr_q + 1'b1;
          if (addr_last) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (scrub_grant) begin
            state_q  <= ST_SCRUB_CHK;
            starve_q <= '0;
          end else if (scrub_pend && client_grant) begin
            starve_q <= starve_q + 1'b1;
          end
        end
        ST_SCRUB_CHK: begin
          if (wb_cor && (cor_cnt_q != '1)) cor_cnt_q <= cor_cnt_q + 1'b1;
          if (any_unc) begin
            scrub_unc_q      <= 1'b1;
            scrub_unc_addr_q <= scrub_addr_q;
          end
          scrub_addr_q <= addr_last ? '0 : scrub_addr_q + 1'b1;
          state_q      <= ST_RUN;
        end
        default: state_q <= ST_RST;
      endcase
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = sram_rdata_i;
  assign bus.rsp_err_cor = sram_err_cor_i;
  assign bus.rsp_err_unc = sram_err_unc_i;
  assign init_done_o      = init_done_q;
  assign scrub_unc_o      = scrub_unc_q;
  assign scrub_unc_addr_o = scrub_unc_addr_q;
  assign scrub_cor_cnt_o  = cor_cnt_q;

endmodule
